nios2_pio_out_ext: RTL and testbench
====================================

Name: nios2_pio_out_ext

Overview:
Parametrised Avalon-MM output PIO, the successor to the fixed 4-bit NIOS2 output ports that drive TX data/control lines. Adds a configurable width, atomic set/clear, a shadow register committed on an external frame strobe, and a timed pulse generator. Sits between the NIOS2 data master (via the interconnect) and TX datapath control pins.

Parameters:
DATA_WIDTH, 4, width of out_port (legal 1..32)
RESET_VALUE, 0, value of out_port and DATA after reset (DATA_WIDTH bits)
PULSE_CNT_WIDTH, 16, width of the pulse length counter (legal 1..32)

Ports:
clk  in  1  system clock; all state on rising edge
reset  in  1  asynchronous, active-high reset
address  in  3  Avalon word address
chipselect  in  1  Avalon select
write_n  in  1  Avalon write, active low
writedata  in  32  Avalon write data
readdata  out  32  Avalon read data; combinational, read latency 0, zero-extended
update_strobe  in  1  synchronous frame strobe from the TX datapath; one-cycle high commits the armed shadow
out_port  out  DATA_WIDTH  registered output, equal to DATA
irq  out  1  level interrupt (present only with NIOS2_PIO_IRQ_EN)

Behaviour:
- wr = chipselect & ~write_n. Only the low DATA_WIDTH / PULSE_CNT_WIDTH bits of writedata are used. Reads of write-only or unused fields return 0.
- Register map:
  0 DATA R/W: DATA <= wd.
  1 SHADOW R/W: staging value; reset 0.
  2 OUTSET W: DATA <= DATA | wd.
  3 OUTCLR W: DATA <= DATA & ~wd.
  4 PULSE_LEN R/W: reset 1; a value of 0 behaves as 1.
  5 PULSE W: starts a pulse with mask = wd; read returns the active mask (0 when idle).
  6 CTRL R/W: bit0 ARM (write 1 arms, write 0 disarms, self-clears on commit); bit1 IMMEDIATE; bit2 IRQ_EN.
  7 STATUS: bit0 BUSY (RO); bit1 ARMED (RO); bit2 OVERRUN (sticky, W1C); bit3 DONE (sticky, W1C).
- Reset: DATA=RESET_VALUE, SHADOW=0, PULSE_LEN=1, CTRL=0, STATUS=0, pulse FSM IDLE, count=0, mask=0, irq=0.
- out_port = DATA. Register writes appear on out_port one cycle after the write cycle.
- Pulse FSM states: IDLE and ACTIVE.
  - IDLE, write to PULSE: DATA ^= mask, count <= max(PULSE_LEN,1), go to ACTIVE, BUSY=1.
  - ACTIVE: count decrements each cycle. When count==1: DATA ^= mask (revert), mask <= 0, DONE <= 1, go to IDLE. The inverted bits are therefore held for exactly PULSE_LEN cycles.
  - ACTIVE, write to PULSE: write ignored, OVERRUN <= 1, count unchanged.
- Shadow commit: when ARMED and (update_strobe or IMMEDIATE), DATA <= SHADOW and ARM clears.
  - ARM is registered, so the earliest commit is the cycle after the CTRL write.
  - Writing SHADOW while armed replaces the committed value.
- Same-cycle conflicts:
  - An Avalon write to 0/2/3/5 beats a commit; the commit is deferred and ARM stays set.
  - The pulse-end revert XOR is applied on top of the result of any same-cycle write or commit.
  - A W1C write to DONE loses to a DONE set in the same cycle.
- Reset mid-pulse: immediate return to reset values; no revert is performed.

Optional Feature:
NIOS2_PIO_IRQ_EN
- Defined: irq port exists, irq = CTRL.IRQ_EN & (DONE | OVERRUN). irq is registered and clears the cycle after the W1C write.
- Undefined: no irq port; CTRL bit2 is read-only 0. DONE and OVERRUN remain visible in STATUS.

Test Plan:
- Reset, DATA_WIDTH=4, RESET_VALUE=4'hA -> out_port=4'hA, STATUS=0, PULSE_LEN read=1; deassert reset, write DATA=0x5 -> out_port=0x5 next cycle, read addr0=0x00000005.
- DATA=0x5, OUTSET 0x8 then OUTCLR 0x1 -> out_port 0xD then 0xC; reads of addr2 and addr3 return 0.
- PULSE_LEN=3, DATA=0x0, PULSE 0x2 -> out_port 0x2 for exactly 3 cycles then 0x0; BUSY high 3 cycles; DONE=1. A PULSE write while busy -> OVERRUN=1, waveform unchanged.
- SHADOW=0x7, CTRL=0x1 -> out_port unchanged until update_strobe pulse, then 0x7 next cycle, ARMED=0. Repeat with a DATA write in the strobe cycle -> DATA value wins, commit occurs at the next strobe.
- Pulse end coincides with a DATA write of 0x4 and mask 0x1 -> out_port=0x5. Reset asserted mid-pulse -> out_port=RESET_VALUE, BUSY=0 immediately.
- With NIOS2_PIO_IRQ_EN, IRQ_EN=1, pulse completes -> irq=1; STATUS W1C 0x8 -> irq=0 next cycle. Without the macro, CTRL read bit2=0.

Source files
------------

// File: rtl/nios2_pio_out_ext.sv
// nios2_pio_out_ext -- parametrised Avalon-MM output PIO for TX control pins.
//
// Purpose: drives out_port from a DATA register that software can write directly,
// set/clear atomically, load from a shadow register on a frame strobe, or
// invert for a timed number of cycles through the pulse generator.
//
// Optional feature macro: NIOS2_PIO_IRQ_EN
//   defined   -> irq port exists, irq = CTRL.IRQ_EN & (DONE | OVERRUN), registered
//   undefined -> no irq port, CTRL bit2 reads 0
//
// Ports:
//   clk, reset     system clock, asynchronous active-high reset
//   address        Avalon word address (0..7)
//   chipselect     Avalon select
//   write_n        Avalon write strobe, active low
//   writedata      Avalon write data
//   readdata       combinational read data, zero-extended
//   update_strobe  one-cycle frame strobe that commits an armed shadow
//   out_port       registered output, equals DATA
//   irq            level interrupt (only with NIOS2_PIO_IRQ_EN)
module nios2_pio_out_ext #(
  parameter int DATA_WIDTH      = 4,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = {DATA_WIDTH{1'b0}},
  parameter int PULSE_CNT_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [2:0]            address,
  input  logic                  chipselect,
  input  logic                  write_n,
  input  logic [31:0]           writedata,
  output logic [31:0]           readdata,
  input  logic                  update_strobe,
  output logic [DATA_WIDTH-1:0] out_port
`ifdef NIOS2_PIO_IRQ_EN
  ,
  output logic                  irq
`endif
);

  localparam int DW  = DATA_WIDTH;
  localparam int PCW = PULSE_CNT_WIDTH;

  typedef enum logic {ST_IDLE = 1'b0, ST_ACTIVE = 1'b1} state_t;

  state_t         r_state, w_state_nxt;
  logic [DW-1:0]  r_data, w_data_nxt;
  logic [DW-1:0]  r_shadow;
  logic [DW-1:0]  r_mask, w_mask_nxt;
  logic [PCW-1:0] r_pulse_len;
  logic [PCW-1:0] r_count, w_count_nxt;
  logic           r_arm, w_arm_nxt;
  logic           r_immediate;
  logic           r_overrun, w_overrun_nxt;
  logic           r_done, w_done_nxt;
`ifdef NIOS2_PIO_IRQ_EN
  logic           r_irq_en, w_irq_en_nxt;
  logic           r_irq;
`endif

  logic           w_wr;
  logic [DW-1:0]  w_wd;
  logic [PCW-1:0] w_len_eff;
  logic           w_busy;
  logic           w_pulse_start;
  logic           w_pulse_ovr;
  logic           w_pulse_end;
  logic           w_data_wr;
  logic           w_commit;
  logic           w_ctrl_wr;
  logic           w_stat_wr;

  assign w_wr          = chipselect & ~write_n;
  assign w_wd          = writedata[DW-1:0];
  assign w_busy        = (r_state == ST_ACTIVE);
  // A programmed length of 0 behaves as 1.
  assign w_len_eff     = (r_pulse_len == {PCW{1'b0}}) ? PCW'(1) : r_pulse_len;
  assign w_pulse_start = w_wr & (address == 3'd5) & ~w_busy;
  assign w_pulse_ovr   = w_wr & (address == 3'd5) & w_busy;
  assign w_pulse_end   = w_busy & (r_count == PCW'(1));
  // Writes that touch DATA (including an ignored PULSE) defer a pending commit.
  assign w_data_wr     = w_wr & ((address == 3'd0) | (address == 3'd2) |
                                 (address == 3'd3) | (address == 3'd5));
  assign w_commit      = r_arm & (update_strobe | r_immediate) & ~w_data_wr;
  assign w_ctrl_wr     = w_wr & (address == 3'd6);
  assign w_stat_wr     = w_wr & (address == 3'd7);

  // Pulse FSM next state, count and mask.
  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    w_mask_nxt  = r_mask;
    case (r_state)
      ST_IDLE: begin
        if (w_pulse_start) begin
          w_state_nxt = ST_ACTIVE;
          w_count_nxt = w_len_eff;
          w_mask_nxt  = w_wd;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_ACTIVE: begin
        if (w_pulse_end) begin
          w_state_nxt = ST_IDLE;
          w_count_nxt = {PCW{1'b0}};
          w_mask_nxt  = {DW{1'b0}};
        end else begin
          w_count_nxt = r_count - PCW'(1);
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // DATA next value: register write beats commit, pulse-end revert applied last.
  always_comb begin
    w_data_nxt = r_data;
    if (w_data_wr) begin
      case (address)
        3'd0:    w_data_nxt = w_wd;
        3'd2:    w_data_nxt = r_data | w_wd;
        3'd3:    w_data_nxt = r_data & ~w_wd;
        3'd5:    w_data_nxt = w_busy ? r_data : (r_data ^ w_wd);
        default: w_data_nxt = r_data;
      endcase
    end else if (w_commit) begin
      w_data_nxt = r_shadow;
    end else begin
      w_data_nxt = r_data;
    end
    if (w_pulse_end) begin
      w_data_nxt = w_data_nxt ^ r_mask;
    end else begin
      w_data_nxt = w_data_nxt;
    end
  end

  // Control and sticky status next values; a same-cycle set beats a W1C.
  always_comb begin
    w_arm_nxt     = r_arm;
    w_overrun_nxt = r_overrun;
    w_done_nxt    = r_done;
    if (w_ctrl_wr) w_arm_nxt = writedata[0];
    else if (w_commit) w_arm_nxt = 1'b0;
    else w_arm_nxt = r_arm;
    if (w_pulse_ovr) w_overrun_nxt = 1'b1;
    else if (w_stat_wr & writedata[2]) w_overrun_nxt = 1'b0;
    else w_overrun_nxt = r_overrun;
    if (w_pulse_end) w_done_nxt = 1'b1;
    else if (w_stat_wr & writedata[3]) w_done_nxt = 1'b0;
    else w_done_nxt = r_done;
  end

`ifdef NIOS2_PIO_IRQ_EN
  // IRQ enable next value.
  always_comb begin
    w_irq_en_nxt = r_irq_en;
    if (w_ctrl_wr) w_irq_en_nxt = writedata[2];
    else w_irq_en_nxt = r_irq_en;
  end
`endif

  // State registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_data      <= RESET_VALUE;
      r_shadow    <= {DW{1'b0}};
      r_mask      <= {DW{1'b0}};
      r_pulse_len <= PCW'(1);
      r_count     <= {PCW{1'b0}};
      r_arm       <= 1'b0;
      r_immediate <= 1'b0;
      r_overrun   <= 1'b0;
      r_done      <= 1'b0;
`ifdef NIOS2_PIO_IRQ_EN
      r_irq_en    <= 1'b0;
      r_irq       <= 1'b0;
`endif
    end else begin
      r_state     <= w_state_nxt;
      r_data      <= w_data_nxt;
      r_mask      <= w_mask_nxt;
      r_count     <= w_count_nxt;
      r_arm       <= w_arm_nxt;
      r_overrun   <= w_overrun_nxt;
      r_done      <= w_done_nxt;
      if (w_wr & (address == 3'd1)) r_shadow <= w_wd;
      if (w_wr & (address == 3'd4)) r_pulse_len <= writedata[PCW-1:0];
      if (w_ctrl_wr) r_immediate <= writedata[1];
`ifdef NIOS2_PIO_IRQ_EN
      r_irq_en    <= w_irq_en_nxt;
      // Built from next-state values so irq drops the cycle after the W1C.
      r_irq       <= w_irq_en_nxt & (w_done_nxt | w_overrun_nxt);
`endif
    end
  end

  assign out_port = r_data;
`ifdef NIOS2_PIO_IRQ_EN
  assign irq = r_irq;
`endif

  // Combinational read mux; write-only and unused fields read 0.
  always_comb begin
    readdata = 32'h0000_0000;
    case (address)
      3'd0:    readdata = 32'(r_data);
      3'd1:    readdata = 32'(r_shadow);
      3'd4:    readdata = 32'(r_pulse_len);
      3'd5:    readdata = 32'(r_mask);
`ifdef NIOS2_PIO_IRQ_EN
      3'd6:    readdata = {29'd0, r_irq_en, r_immediate, r_arm};
`else
      3'd6:    readdata = {29'd0, 1'b0, r_immediate, r_arm};
`endif
      3'd7:    readdata = {28'd0, r_done, r_overrun, r_arm, w_busy};
      default: readdata = 32'h0000_0000;
    endcase
  end

endmodule

// File: tb/tb_nios2_pio_out_ext.sv
module tb_nios2_pio_out_ext;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [2:0]  address = 3'd0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = 32'd0;
  logic [31:0] readdata;
  logic        update_strobe = 1'b0;
  logic [3:0]  out_port;
`ifdef NIOS2_PIO_IRQ_EN
  logic        irq;
`endif

  int n_pass = 0;
  int n_total = 0;

  nios2_pio_out_ext #(
    .DATA_WIDTH(4),
    .RESET_VALUE(4'hA),
    .PULSE_CNT_WIDTH(16)
  ) dut (
    .clk(clk),
    .reset(reset),
    .address(address),
    .chipselect(chipselect),
    .write_n(write_n),
    .writedata(writedata),
    .readdata(readdata),
    .update_strobe(update_strobe),
    .out_port(out_port)
`ifdef NIOS2_PIO_IRQ_EN
    ,
    .irq(irq)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  waddr;
    logic [31:0] wdata;
    logic [3:0]  exp_out;
    logic [2:0]  raddr;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
  endtask

  // Called at posedge+1; returns at posedge+1 of the following cycle.
  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    @(posedge clk); #1;
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic wr_strobe(input logic [2:0] a, input logic [31:0] d);
    update_strobe = 1'b1;
    wr(a, d);
    update_strobe = 1'b0;
  endtask

  task automatic strobe();
    update_strobe = 1'b1;
    @(posedge clk); #1;
    update_strobe = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic rd(input string nm, input logic [2:0] a, input logic [31:0] exp);
    address = a; #1;
    chk(nm, readdata, exp);
  endtask

  task automatic chk_out(input string nm, input logic [3:0] exp);
    chk(nm, {28'd0, out_port}, {28'd0, exp});
  endtask

  initial begin
    vecs[0] = '{3'd0, 32'h0000_0005, 4'h5, 3'd0, 32'h0000_0005};
    vecs[1] = '{3'd2, 32'h0000_0008, 4'hD, 3'd2, 32'h0000_0000};
    vecs[2] = '{3'd3, 32'h0000_0001, 4'hC, 3'd3, 32'h0000_0000};
    vecs[3] = '{3'd1, 32'h0000_0007, 4'hC, 3'd1, 32'h0000_0007};
    vecs[4] = '{3'd4, 32'h0000_0003, 4'hC, 3'd4, 32'h0000_0003};
    vecs[5] = '{3'd0, 32'h0000_0000, 4'h0, 3'd7, 32'h0000_0000};
    vecs[6] = '{3'd6, 32'h0000_0002, 4'h0, 3'd6, 32'h0000_0002};
    vecs[7] = '{3'd6, 32'h0000_0000, 4'h0, 3'd6, 32'h0000_0000};
    vecs[8] = '{3'd0, 32'hFFFF_FF1F, 4'hF, 3'd0, 32'h0000_000F};
    vecs[9] = '{3'd0, 32'h0000_0000, 4'h0, 3'd0, 32'h0000_0000};

    // Reset state
    @(posedge clk); @(posedge clk); #1;
    chk_out("rst_out", 4'hA);
    rd("rst_status", 3'd7, 32'h0);
    rd("rst_plen", 3'd4, 32'h1);
    rd("rst_shadow", 3'd1, 32'h0);
    reset = 1'b0;
    tick();

    // Table-driven register map vectors
    for (int i = 0; i < 10; i++) begin
      wr(vecs[i].waddr, vecs[i].wdata);
      chk_out($sformatf("vec%0d_out", i), vecs[i].exp_out);
      rd($sformatf("vec%0d_rd", i), vecs[i].raddr, vecs[i].exp_rd);
    end

    // Pulse of length 3 with an overrun write mid-pulse
    wr(3'd6, 32'h4);
`ifdef NIOS2_PIO_IRQ_EN
    rd("ctrl_irqen", 3'd6, 32'h4);
`else
    rd("ctrl_irqen_ro", 3'd6, 32'h0);
`endif
    wr(3'd4, 32'h3);
    wr(3'd5, 32'h2);
    chk_out("pul_c1_out", 4'h2);
    rd("pul_c1_stat", 3'd7, 32'h1);
    rd("pul_c1_mask", 3'd5, 32'h2);
    wr(3'd5, 32'h4);
    chk_out("pul_c2_out", 4'h2);
    rd("pul_c2_stat", 3'd7, 32'h5);
    tick();
    chk_out("pul_c3_out", 4'h2);
    tick();
    chk_out("pul_end_out", 4'h0);
    rd("pul_end_stat", 3'd7, 32'hC);
    rd("pul_end_mask", 3'd5, 32'h0);
`ifdef NIOS2_PIO_IRQ_EN
    chk("irq_set", {31'd0, irq}, 32'h1);
`endif
    wr(3'd7, 32'hC);
    rd("w1c_stat", 3'd7, 32'h0);
`ifdef NIOS2_PIO_IRQ_EN
    chk("irq_clr", {31'd0, irq}, 32'h0);
`endif

    // Shadow commit on strobe
    wr(3'd1, 32'h7);
    wr(3'd6, 32'h1);
    rd("arm_stat", 3'd7, 32'h2);
    chk_out("arm_hold", 4'h0);
    tick();
    chk_out("arm_hold2", 4'h0);
    strobe();
    chk_out("commit_out", 4'h7);
    rd("commit_stat", 3'd7, 32'h0);

    // DATA write in strobe cycle defers commit
    wr(3'd1, 32'h3);
    wr(3'd6, 32'h1);
    wr_strobe(3'd0, 32'h9);
    chk_out("defer_out", 4'h9);
    rd("defer_stat", 3'd7, 32'h2);
    strobe();
    chk_out("defer_commit", 4'h3);
    rd("defer_stat2", 3'd7, 32'h0);

    // Pulse end coincides with a DATA write
    wr(3'd4, 32'h2);
    wr(3'd0, 32'h0);
    wr(3'd5, 32'h1);
    chk_out("coin_c1", 4'h1);
    tick();
    wr(3'd0, 32'h4);
    chk_out("coin_out", 4'h5);
    rd("coin_stat", 3'd7, 32'h8);
    wr(3'd7, 32'h8);
    rd("coin_clr", 3'd7, 32'h0);

    // W1C of DONE loses to a same-cycle DONE set
    wr(3'd4, 32'h1);
    wr(3'd5, 32'h1);
    chk_out("w1c_c1", 4'h4);
    wr(3'd7, 32'h8);
    chk_out("w1c_out", 4'h5);
    rd("w1c_lose", 3'd7, 32'h8);
    wr(3'd7, 32'h8);

    // PULSE_LEN of 0 behaves as 1
    wr(3'd4, 32'h0);
    rd("len0_rd", 3'd4, 32'h0);
    wr(3'd5, 32'h2);
    chk_out("len0_c1", 4'h7);
    rd("len0_busy", 3'd7, 32'h1);
    tick();
    chk_out("len0_end", 4'h5);
    rd("len0_done", 3'd7, 32'h8);
    wr(3'd7, 32'h8);

    // Reset asserted mid-pulse
    wr(3'd4, 32'h5);
    wr(3'd5, 32'h3);
    chk_out("mid_c1", 4'h6);
    tick();
    reset = 1'b1; #1;
    chk_out("mid_rst_out", 4'hA);
    rd("mid_rst_stat", 3'd7, 32'h0);
    tick();
    reset = 1'b0;
    tick(); tick();
    chk_out("post_rst_out", 4'hA);
    rd("post_rst_plen", 3'd4, 32'h1);
    rd("post_rst_mask", 3'd5, 32'h0);
    rd("post_rst_stat", 3'd7, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
